// File: rtl/pdu_tx_deparse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pdu_tx_deparse                                                  |
// | Function : descriptor-driven TX deparser, byte-swapped flits to Avalon-ST  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pdu_tx_deparse #(
  parameter int MAX_PKT_BYTES = 9600,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_desc_valid,
  input  logic [15:0]          in_desc_size,
  output logic                 in_desc_ready,
  input  logic [511:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [511:0]         out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [5:0]           out_empty,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] out_pkt_cnt,
  output logic [CNT_WIDTH-1:0] out_bad_desc_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t               r_state;
  logic [15:0]          r_flits_left;
  logic [5:0]           r_last_empty;
  logic                 r_first;
  logic [CNT_WIDTH-1:0] r_pkt_cnt;
  logic [CNT_WIDTH-1:0] r_bad_cnt;

  logic [511:0]         r_skid_data  [2];
  logic [5:0]           r_skid_empty [2];
  logic [1:0]           r_skid_sop;
  logic [1:0]           r_skid_eop;
  logic                 r_rd_ptr;
  logic                 r_wr_ptr;
  logic [1:0]           r_occ;

  logic [511:0]         w_swap;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_last_flit;
  logic                 w_desc_hs;
  logic                 w_desc_bad;
  logic [16:0]          w_size_rnd;
  logic [15:0]          w_new_flits;
  logic [5:0]           w_new_empty;

  for (genvar gi = 0; gi < 64; gi++) begin : g_swap
    assign w_swap[8*gi +: 8] = in_data[8*(63-gi) +: 8];
  end

  assign in_ready    = (r_state == S_STREAM) && (r_occ != 2'd2);
  assign w_push      = in_valid && in_ready;
  assign out_valid   = (r_occ != 2'd0);
  assign w_pop       = out_valid && out_ready;
  assign w_last_flit = w_push && (r_flits_left == 16'd1);

  // The last-flit cycle also opens the descriptor port so packets chain without a bubble.
  assign in_desc_ready = !rst && ((r_state == S_IDLE) || w_last_flit);
  assign w_desc_hs     = in_desc_valid && in_desc_ready;
  assign w_desc_bad    = (in_desc_size == 16'd0) ||
                         ({16'd0, in_desc_size} > 32'(MAX_PKT_BYTES));

  assign w_size_rnd  = {1'b0, in_desc_size} + 17'd63;
  assign w_new_flits = 16'(w_size_rnd >> 6);
  assign w_new_empty = 6'd0 - in_desc_size[5:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_flits_left <= 16'd0;
      r_last_empty <= 6'd0;
      r_first      <= 1'b0;
      r_bad_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_desc_hs) begin
            if (w_desc_bad) begin
              r_bad_cnt <= r_bad_cnt + c_cnt_one;
            end else begin
              r_flits_left <= w_new_flits;
              r_last_empty <= w_new_empty;
              r_first      <= 1'b1;
              r_state      <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (w_push) begin
            r_first      <= 1'b0;
            r_flits_left <= r_flits_left - 16'd1;
            if (w_last_flit) begin
              if (w_desc_hs && !w_desc_bad) begin
                r_flits_left <= w_new_flits;
                r_last_empty <= w_new_empty;
                r_first      <= 1'b1;
              end else begin
                if (w_desc_hs) begin
                  r_bad_cnt <= r_bad_cnt + c_cnt_one;
                end
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_skid_data[i]  <= '0;
        r_skid_empty[i] <= 6'd0;
      end
      r_skid_sop <= 2'b00;
      r_skid_eop <= 2'b00;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_occ      <= 2'd0;
      r_pkt_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_skid_data[r_wr_ptr]  <= w_swap;
        r_skid_sop[r_wr_ptr]   <= r_first;
        r_skid_eop[r_wr_ptr]   <= (r_flits_left == 16'd1);
        r_skid_empty[r_wr_ptr] <= (r_flits_left == 16'd1) ? r_last_empty : 6'd0;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        if (out_eop) begin
          r_pkt_cnt <= r_pkt_cnt + c_cnt_one;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign out_data         = r_skid_data[r_rd_ptr];
  assign out_sop          = r_skid_sop[r_rd_ptr];
  assign out_eop          = r_skid_eop[r_rd_ptr];
  assign out_empty        = r_skid_empty[r_rd_ptr];
  assign out_pkt_cnt      = r_pkt_cnt;
  assign out_bad_desc_cnt = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pdu_tx_deparse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pdu_tx_deparse                                               |
// | Function : randomized bench for pdu_tx_deparse with a packet-level model   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pdu_tx_deparse;
  localparam int MAXB = 9600;
  localparam int CW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_desc_valid;
  logic [15:0]   in_desc_size;
  logic          in_desc_ready;
  logic [511:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [511:0]  out_data;
  logic          out_sop;
  logic          out_eop;
  logic [5:0]    out_empty;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_pkt_cnt;
  logic [CW-1:0] out_bad_desc_cnt;

  pdu_tx_deparse #(.MAX_PKT_BYTES(MAXB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_desc_valid(in_desc_valid), .in_desc_size(in_desc_size), .in_desc_ready(in_desc_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pkt_cnt(out_pkt_cnt), .out_bad_desc_cnt(out_bad_desc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
    int           cyc;
  } beat_t;

  beat_t        obs_q[$];
  beat_t        exp_q[$];
  logic [511:0] flit_q[$];
  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_pkts = 0;
  int exp_bad  = 0;
  bit use_ramp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      beat_t b;
      b.data = out_data; b.sop = out_sop; b.eop = out_eop; b.empty = out_empty; b.cyc = cyc;
      obs_q.push_back(b);
    end
  end

  function automatic logic [511:0] gen_flit();
    logic [511:0] v;
    for (int i = 0; i < 64; i++) v[8*i +: 8] = use_ramp ? 8'(i) : 8'($urandom);
    return v;
  endfunction

  // Packet-level model: a good descriptor becomes ceil(size/64) byte-reversed beats.
  task automatic plan(input int sizes[$]);
    foreach (sizes[k]) begin
      int s;
      s = sizes[k];
      if (s == 0 || s > MAXB) begin
        exp_bad++;
      end else begin
        int nb;
        nb = (s + 63) / 64;
        for (int b = 0; b < nb; b++) begin
          logic [511:0] d;
          beat_t e;
          d = gen_flit();
          flit_q.push_back(d);
          e.data  = {<<8{d}};
          e.sop   = (b == 0);
          e.eop   = (b == nb - 1);
          e.empty = (b == nb - 1) ? 6'((64 - (s % 64)) % 64) : 6'd0;
          e.cyc   = 0;
          exp_q.push_back(e);
        end
        exp_pkts++;
      end
    end
  endtask

  task automatic drive(input int sizes[$], input int rdy_pct, input int budget);
    int target;
    int deadline;
    target   = exp_q.size();
    deadline = cyc + budget;
    fork
      begin
        bit hs;
        foreach (sizes[k]) begin
          in_desc_valid = 1'b1;
          in_desc_size  = 16'(sizes[k]);
          hs = 1'b0;
          while (!hs && cyc < deadline) begin
            @(negedge clk); hs = in_desc_ready;
            @(posedge clk); #1;
          end
        end
        in_desc_valid = 1'b0;
      end
      begin
        bit hs;
        while (flit_q.size() > 0 && cyc < deadline) begin
          in_valid = 1'b1;
          in_data  = flit_q[0];
          @(negedge clk); hs = in_ready;
          @(posedge clk); #1;
          if (hs) void'(flit_q.pop_front());
        end
        in_valid = 1'b0;
      end
      begin
        while (obs_q.size() < target && cyc < deadline) begin
          out_ready = ($urandom_range(99) < rdy_pct);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_desc_valid = 1'b0; in_desc_size = 16'd0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_checks++; if ({out_sop, out_eop} !== 2'b00) begin n_errors++; $display("FAIL reset sop/eop: got %b%b expected 00", out_sop, out_eop); end
    n_checks++; if (out_empty !== 6'd0 || out_data !== 512'd0) begin n_errors++; $display("FAIL reset empty/data: got empty=%0d data=%h expected 0", out_empty, out_data); end
    n_checks++; if (out_pkt_cnt !== 0 || out_bad_desc_cnt !== 0) begin n_errors++; $display("FAIL reset counters: got %0d/%0d expected 0/0", out_pkt_cnt, out_bad_desc_cnt); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_desc_ready !== 1'b1) begin n_errors++; $display("FAIL idle in_desc_ready: got %b expected 1", in_desc_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int sz[$];
    obs_q.delete(); exp_q.delete(); flit_q.delete();
    sz.push_back(64);
    use_ramp = 1'b1; plan(sz); use_ramp = 1'b0;
    drive(sz, 100, 50);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL single beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].sop !== exp_q[i].sop || obs_q[i].eop !== exp_q[i].eop || obs_q[i].empty !== exp_q[i].empty) begin
        n_errors++;
        $display("FAIL single beat%0d: got sop=%b eop=%b empty=%0d data=%h expected sop=%b eop=%b empty=%0d data=%h", i, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, obs_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0].data[7:0] !== 8'h3F) begin n_errors++; $display("FAIL single byte0: got %h expected 3f", obs_q[0].data[7:0]); end
    end
    n_checks++; if (out_pkt_cnt !== CW'(exp_pkts)) begin n_errors++; $display("FAIL single pkt_cnt: got %0d expected %0d", out_pkt_cnt, exp_pkts); end
  endtask

  task automatic test_multi();
    int sz[$];
    obs_q.delete(); exp_q.delete(); flit_q.delete();
    sz.push_back(130);
    plan(sz);
    drive(sz, 100, 60);
    n_checks++; if (obs_q.size() != 3) begin n_errors++; $display("FAIL multi beats: got %0d expected 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].sop !== exp_q[i].sop || obs_q[i].eop !== exp_q[i].eop || obs_q[i].empty !== exp_q[i].empty) begin
        n_errors++;
        $display("FAIL multi beat%0d: got sop=%b eop=%b empty=%0d expected sop=%b eop=%b empty=%0d", i, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty);
      end
    end
    if (obs_q.size() == 3) begin
      n_checks++; if (obs_q[2].empty !== 6'd62) begin n_errors++; $display("FAIL multi last empty: got %0d expected 62", obs_q[2].empty); end
    end
    n_checks++; if (out_pkt_cnt !== CW'(exp_pkts)) begin n_errors++; $display("FAIL multi pkt_cnt: got %0d expected %0d", out_pkt_cnt, exp_pkts); end
  endtask

  task automatic test_back_to_back();
    int sz[$];
    obs_q.delete(); exp_q.delete(); flit_q.delete();
    sz.push_back(65); sz.push_back(64);
    plan(sz);
    drive(sz, 100, 60);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL b2b beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].sop !== exp_q[i].sop || obs_q[i].eop !== exp_q[i].eop || obs_q[i].empty !== exp_q[i].empty || obs_q[i].cyc !== obs_q[0].cyc + i) begin
        n_errors++;
        $display("FAIL b2b beat%0d: got sop=%b eop=%b empty=%0d cycle=%0d expected sop=%b eop=%b empty=%0d cycle=%0d", i, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, obs_q[i].cyc, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, obs_q[0].cyc + i);
      end
    end
    n_checks++; if (out_pkt_cnt !== CW'(exp_pkts)) begin n_errors++; $display("FAIL b2b pkt_cnt: got %0d expected %0d", out_pkt_cnt, exp_pkts); end
  endtask

  task automatic test_bad_desc();
    int sz[$];
    int bad_sizes[2];
    bad_sizes[0] = 0; bad_sizes[1] = MAXB + 1;
    obs_q.delete(); exp_q.delete(); flit_q.delete();
    in_valid = 1'b1; in_data = gen_flit();
    for (int k = 0; k < 2; k++) begin
      in_desc_valid = 1'b1; in_desc_size = 16'(bad_sizes[k]);
      @(negedge clk);
      n_checks++; if (in_desc_ready !== 1'b1) begin n_errors++; $display("FAIL bad desc_ready%0d: got %b expected 1", k, in_desc_ready); end
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bad in_ready%0d: got %b expected 0", k, in_ready); end
      @(posedge clk); #1;
    end
    exp_bad += 2;
    in_desc_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL bad idle: got in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid); end
    n_checks++; if (out_bad_desc_cnt !== CW'(exp_bad)) begin n_errors++; $display("FAIL bad count: got %0d expected %0d", out_bad_desc_cnt, exp_bad); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sz.push_back(60);
    plan(sz);
    drive(sz, 100, 40);
    n_checks++; if (obs_q.size() != 1) begin n_errors++; $display("FAIL bad follow beats: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_checks++;
      if (obs_q[0].data !== exp_q[0].data || obs_q[0].sop !== 1'b1 || obs_q[0].eop !== 1'b1 || obs_q[0].empty !== 6'd4) begin
        n_errors++;
        $display("FAIL bad follow beat: got sop=%b eop=%b empty=%0d expected sop=1 eop=1 empty=4", obs_q[0].sop, obs_q[0].eop, obs_q[0].empty);
      end
    end
  endtask

  task automatic test_backpressure();
    int sz[$];
    int pushes;
    int deadline;
    bit hs;
    obs_q.delete(); exp_q.delete(); flit_q.delete();
    sz.push_back(256);
    plan(sz);
    out_ready = 1'b0;
    deadline = cyc + 20;
    in_desc_valid = 1'b1; in_desc_size = 16'd256;
    hs = 1'b0;
    while (!hs && cyc < deadline) begin
      @(negedge clk); hs = in_desc_ready;
      @(posedge clk); #1;
    end
    in_desc_valid = 1'b0;
    pushes = 0;
    in_valid = 1'b1; in_data = flit_q[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      hs = in_ready;
      if (c > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== exp_q[0].data) begin
          n_errors++;
          $display("FAIL hold cycle%0d: got valid=%b sop=%b data=%h expected valid=1 sop=1 data=%h", c, out_valid, out_sop, out_data, exp_q[0].data);
        end
      end
      @(posedge clk); #1;
      if (hs) begin
        void'(flit_q.pop_front());
        pushes++;
        in_data = flit_q[0];
      end
    end
    n_checks++; if (pushes != 2) begin n_errors++; $display("FAIL hold pushes: got %0d expected 2", pushes); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL hold in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    sz.delete();
    drive(sz, 100, 40);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL hold beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].sop !== exp_q[i].sop || obs_q[i].eop !== exp_q[i].eop || obs_q[i].empty !== exp_q[i].empty) begin
        n_errors++;
        $display("FAIL hold beat%0d: got sop=%b eop=%b empty=%0d data=%h expected sop=%b eop=%b empty=%0d data=%h", i, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, obs_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
    n_checks++; if (out_pkt_cnt !== CW'(exp_pkts)) begin n_errors++; $display("FAIL hold pkt_cnt: got %0d expected %0d", out_pkt_cnt, exp_pkts); end
  endtask

  task automatic test_random();
    int sz[$];
    obs_q.delete(); exp_q.delete(); flit_q.delete();
    for (int k = 0; k < 12; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      sz.push_back(0);
      else if (r == 1) sz.push_back(MAXB + 1 + $urandom_range(0, 200));
      else if (r == 2) sz.push_back($urandom_range(1, 64));
      else             sz.push_back($urandom_range(65, 700));
    end
    sz.push_back(MAXB);
    plan(sz);
    drive(sz, 60, 4000);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL random beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].sop !== exp_q[i].sop || obs_q[i].eop !== exp_q[i].eop || obs_q[i].empty !== exp_q[i].empty) begin
        n_errors++;
        $display("FAIL random beat%0d: got sop=%b eop=%b empty=%0d expected sop=%b eop=%b empty=%0d", i, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty);
      end
    end
    n_checks++; if (out_pkt_cnt !== CW'(exp_pkts)) begin n_errors++; $display("FAIL random pkt_cnt: got %0d expected %0d", out_pkt_cnt, exp_pkts); end
    n_checks++; if (out_bad_desc_cnt !== CW'(exp_bad)) begin n_errors++; $display("FAIL random bad_cnt: got %0d expected %0d", out_bad_desc_cnt, exp_bad); end
  endtask

  task automatic test_reset_mid();
    int sz[$];
    int sent;
    int deadline;
    bit hs;
    obs_q.delete(); exp_q.delete(); flit_q.delete();
    sz.push_back(256);
    plan(sz);
    out_ready = 1'b0;
    deadline = cyc + 30;
    in_desc_valid = 1'b1; in_desc_size = 16'd256;
    hs = 1'b0;
    while (!hs && cyc < deadline) begin
      @(negedge clk); hs = in_desc_ready;
      @(posedge clk); #1;
    end
    in_desc_valid = 1'b0;
    sent = 0;
    in_valid = 1'b1;
    while (sent < 2 && cyc < deadline) begin
      in_data = flit_q[0];
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      if (hs) begin void'(flit_q.pop_front()); sent++; end
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin n_errors++; $display("FAIL midrst flags: got valid=%b sop=%b eop=%b expected 000", out_valid, out_sop, out_eop); end
    n_checks++; if (out_data !== 512'd0 || out_empty !== 6'd0) begin n_errors++; $display("FAIL midrst data: got empty=%0d data=%h expected 0", out_empty, out_data); end
    n_checks++; if (out_pkt_cnt !== 0 || out_bad_desc_cnt !== 0) begin n_errors++; $display("FAIL midrst counters: got %0d/%0d expected 0/0", out_pkt_cnt, out_bad_desc_cnt); end
    obs_q.delete(); exp_q.delete(); flit_q.delete();
    exp_pkts = 0; exp_bad = 0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    sz.delete(); sz.push_back(64);
    plan(sz);
    drive(sz, 100, 40);
    n_checks++; if (obs_q.size() != 1) begin n_errors++; $display("FAIL midrst beats: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_checks++;
      if (obs_q[0].data !== exp_q[0].data || obs_q[0].sop !== 1'b1 || obs_q[0].eop !== 1'b1 || obs_q[0].empty !== 6'd0) begin
        n_errors++;
        $display("FAIL midrst beat: got sop=%b eop=%b empty=%0d expected sop=1 eop=1 empty=0", obs_q[0].sop, obs_q[0].eop, obs_q[0].empty);
      end
    end
    n_checks++; if (out_pkt_cnt !== 1) begin n_errors++; $display("FAIL midrst pkt_cnt: got %0d expected 1", out_pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_bad_desc();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
